// File: rtl/vmask_seq_pkg.sv
// Shared types and default geometry for the sequential vector lane-mask unit.
// Imported by the interface, the lane generator, the top and the bench.
package vmask_seq_pkg;

    localparam int unsigned VLEN_DEF      = 128;
    localparam int unsigned NUM_LANES_DEF = 4;
    localparam int unsigned ELEM_W_DEF    = $clog2(VLEN_DEF) + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } vmask_state_t;

    // Command fields at the default geometry.
    typedef struct packed {
        logic [VLEN_DEF-1:0]   v0;
        logic                  mask_enable;
        logic [ELEM_W_DEF-1:0] vstart;
        logic [ELEM_W_DEF-1:0] vl;
    } vmask_cmd_t;

    // Keeps derived index widths at least one bit when VLEN == NUM_LANES.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/vmask_seq_unit_if.sv
// Command and micro-op stream bundle between issue logic and vmask_seq_unit.
// active_cnt exists only when VMASK_SEQ_POPCOUNT_EN is defined.
interface vmask_seq_unit_if
    import vmask_seq_pkg::*;
#(
    parameter int unsigned VLEN      = VLEN_DEF,
    parameter int unsigned NUM_LANES = NUM_LANES_DEF
);
    localparam int unsigned ELEM_W = $clog2(VLEN) + 1;
    localparam int unsigned UOP_W  = clog2_min1(VLEN / NUM_LANES);

    logic                 cmd_valid;
    logic                 cmd_ready;
    logic [VLEN-1:0]      v0;
    logic                 mask_enable;
    logic [ELEM_W-1:0]    vstart;
    logic [ELEM_W-1:0]    vl;
    logic                 flush;
    logic                 uop_valid;
    logic                 uop_ready;
    logic [UOP_W-1:0]     uop_num;
    logic [NUM_LANES-1:0] lane_en;
    logic                 uop_last;
    logic                 done;
`ifdef VMASK_SEQ_POPCOUNT_EN
    logic [ELEM_W-1:0]    active_cnt;
`endif

    // Issue side: offers commands, consumes micro-ops.
    modport master (
        output cmd_valid, v0, mask_enable, vstart, vl, flush, uop_ready,
        input  cmd_ready, uop_valid, uop_num, lane_en, uop_last, done
`ifdef VMASK_SEQ_POPCOUNT_EN
        , input active_cnt
`endif
    );

    // Sequencer side.
    modport slave (
        input  cmd_valid, v0, mask_enable, vstart, vl, flush, uop_ready,
        output cmd_ready, uop_valid, uop_num, lane_en, uop_last, done
`ifdef VMASK_SEQ_POPCOUNT_EN
        , output active_cnt
`endif
    );

endinterface

// File: rtl/vmask_seq_unit_lane_gen.sv
// Combinational lane-enable and last-micro-op generation for one micro-op index
// against the captured mask snapshot and the [vstart, vl) bounds.
module vmask_lane_gen
    import vmask_seq_pkg::*;
#(
    parameter  int unsigned VLEN      = VLEN_DEF,
    parameter  int unsigned NUM_LANES = NUM_LANES_DEF,
    localparam int unsigned ELEM_W    = $clog2(VLEN) + 1,
    localparam int unsigned UOP_W     = clog2_min1(VLEN / NUM_LANES)
) (
    input  logic [UOP_W-1:0]     uop_num,
    input  logic [VLEN-1:0]      v0_snap,
    input  logic                 mask_enable,
    input  logic [ELEM_W-1:0]    vstart,
    input  logic [ELEM_W-1:0]    vl,
    output logic [NUM_LANES-1:0] lane_en,
    output logic                 uop_last
);
    // One extra bit so element indices past vl never wrap into range.
    localparam int unsigned EW1     = ELEM_W + 1;
    localparam int unsigned LANE_SH = $clog2(NUM_LANES);
    localparam int unsigned IDX_W   = clog2_min1(VLEN);

    logic [EW1-1:0] base;
    logic [EW1-1:0] lo;
    logic [EW1-1:0] hi;
    logic [EW1-1:0] e;

    // NOTE: every variable gets a default before the loop so no latch is inferred.
    always_comb begin
        base     = EW1'(uop_num) << LANE_SH;
        lo       = EW1'(vstart);
        hi       = EW1'(vl);
        uop_last = (base + EW1'(NUM_LANES)) >= hi;
        lane_en  = '0;
        e        = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            e          = base + EW1'(i);
            // The v0 lookup only matters when e < vl <= VLEN, so the truncated index is safe.
            lane_en[i] = (e >= lo) && (e < hi) && (!mask_enable || v0_snap[e[IDX_W-1:0]]);
        end
    end

endmodule

// File: rtl/vmask_seq_unit.sv
// Sequential lane-mask unit: accepts a command, then streams one lane-enable
// micro-op per handshake over [vstart, vl). Optional VMASK_SEQ_POPCOUNT_EN adds active_cnt.
module vmask_seq_unit
    import vmask_seq_pkg::*;
#(
    parameter int unsigned VLEN      = VLEN_DEF,
    parameter int unsigned NUM_LANES = NUM_LANES_DEF
) (
    input  logic             CLK,
    input  logic             nRST,
    vmask_seq_unit_if.slave  bus
);
    localparam int unsigned ELEM_W  = $clog2(VLEN) + 1;
    localparam int unsigned UOP_W   = clog2_min1(VLEN / NUM_LANES);
    localparam int unsigned LANE_SH = $clog2(NUM_LANES);

    // Follows the module parameters; the package struct is the default-geometry view.
    typedef struct packed {
        logic [VLEN-1:0]   v0;
        logic              mask_enable;
        logic [ELEM_W-1:0] vstart;
        logic [ELEM_W-1:0] vl;
    } cmd_t;

    vmask_state_t         state;
    vmask_state_t         state_nxt;
    logic                 rst_done;
    cmd_t                 snap;
    logic [UOP_W-1:0]     uop_num_q;
    logic [NUM_LANES-1:0] lane_en_raw;
    logic                 uop_last_raw;
    logic                 cmd_ready_o;
    logic                 uop_valid_o;
    logic                 done_o;
    logic                 accept;
    logic                 fire;

    assign accept = bus.cmd_valid && cmd_ready_o && !bus.flush;
    assign fire   = uop_valid_o && bus.uop_ready;

    always_ff @(posedge CLK) begin
        if (!nRST) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (bus.flush) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (accept) state_nxt = (bus.vstart >= bus.vl) ? DONE : ISSUE;
                ISSUE:   if (fire && uop_last_raw) state_nxt = DONE;
                DONE:    state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // cmd_ready also waits for rst_done so it stays low through reset.
    always_comb begin
        cmd_ready_o = 1'b0;
        uop_valid_o = 1'b0;
        done_o      = 1'b0;
        case (state)
            IDLE:    cmd_ready_o = rst_done;
            ISSUE:   uop_valid_o = 1'b1;
            DONE:    done_o      = 1'b1;
            default: ;
        endcase
    end

    // NOTE: the snapshot is a plain register, so it is cleared in reset with the rest of the state.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            rst_done  <= 1'b0;
            snap      <= '0;
            uop_num_q <= '0;
        end else begin
            rst_done <= 1'b1;
            if (accept) begin
                snap.v0          <= bus.v0;
                snap.mask_enable <= bus.mask_enable;
                snap.vstart      <= bus.vstart;
                snap.vl          <= bus.vl;
                uop_num_q        <= UOP_W'(bus.vstart >> LANE_SH);
            end else if (fire && !uop_last_raw) begin
                uop_num_q <= uop_num_q + UOP_W'(1);
            end
        end
    end

    vmask_lane_gen #(
        .VLEN      (VLEN),
        .NUM_LANES (NUM_LANES)
    ) u_lane_gen (
        .uop_num     (uop_num_q),
        .v0_snap     (snap.v0),
        .mask_enable (snap.mask_enable),
        .vstart      (snap.vstart),
        .vl          (snap.vl),
        .lane_en     (lane_en_raw),
        .uop_last    (uop_last_raw)
    );

    assign bus.cmd_ready = cmd_ready_o;
    assign bus.uop_valid = uop_valid_o;
    assign bus.done      = done_o;
    assign bus.uop_num   = uop_valid_o ? uop_num_q    : '0;
    assign bus.lane_en   = uop_valid_o ? lane_en_raw  : '0;
    assign bus.uop_last  = uop_valid_o && uop_last_raw;

`ifdef VMASK_SEQ_POPCOUNT_EN
    logic [ELEM_W-1:0] lane_pop;
    logic [ELEM_W-1:0] active_cnt_q;

    always_comb begin
        lane_pop = '0;
        for (int i = 0; i < NUM_LANES; i++) lane_pop = lane_pop + ELEM_W'(lane_en_raw[i]);
    end

    always_ff @(posedge CLK) begin
        if (!nRST)                  active_cnt_q <= '0;
        else if (bus.flush || accept) active_cnt_q <= '0;
        else if (fire)              active_cnt_q <= active_cnt_q + lane_pop;
    end

    assign bus.active_cnt = active_cnt_q;
`endif

    vl_in_range: assert property (@(posedge CLK) disable iff (!nRST)
        accept |-> (bus.vl <= ELEM_W'(VLEN)));

endmodule

// File: tb/tb_vmask_seq_unit.sv
// Directed bench for vmask_seq_unit at VLEN=128, NUM_LANES=4; also covers
// active_cnt when VMASK_SEQ_POPCOUNT_EN is defined.
module tb_vmask_seq_unit;
    import vmask_seq_pkg::*;

    localparam int unsigned VLEN      = VLEN_DEF;
    localparam int unsigned NUM_LANES = NUM_LANES_DEF;

    logic clk  = 1'b0;
    logic nrst = 1'b0;
    int   n_assert = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    vmask_seq_unit_if #(.VLEN(VLEN), .NUM_LANES(NUM_LANES)) bus ();

    vmask_seq_unit #(.VLEN(VLEN), .NUM_LANES(NUM_LANES)) dut (
        .CLK  (clk),
        .nRST (nrst),
        .bus  (bus)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_uop(input string tag, input int num, input logic [3:0] lane, input logic last);
        check({tag, "_valid"}, bus.uop_valid, 1'b1);
        check({tag, "_num"},   bus.uop_num,   num);
        check({tag, "_lane"},  bus.lane_en,   lane);
        check({tag, "_last"},  bus.uop_last,  last);
        check({tag, "_done"},  bus.done,      1'b0);
    endtask

    task automatic check_idle_outputs(input string tag, input logic ready);
        check({tag, "_ready"}, bus.cmd_ready, ready);
        check({tag, "_valid"}, bus.uop_valid, 1'b0);
        check({tag, "_done"},  bus.done,      1'b0);
        check({tag, "_num"},   bus.uop_num,   '0);
        check({tag, "_lane"},  bus.lane_en,   '0);
        check({tag, "_last"},  bus.uop_last,  1'b0);
    endtask

    // Offers cmd while the unit is idle and returns one cycle after the handshake edge.
    task automatic issue(input string tag, input vmask_cmd_t c);
        check({tag, "_cmd_ready"}, bus.cmd_ready, 1'b1);
        bus.cmd_valid   = 1'b1;
        bus.v0          = c.v0;
        bus.mask_enable = c.mask_enable;
        bus.vstart      = c.vstart;
        bus.vl          = c.vl;
        tick();
        bus.cmd_valid = 1'b0;
    endtask

    task automatic check_done(input string tag);
        check({tag, "_done"},     bus.done,      1'b1);
        check({tag, "_valid"},    bus.uop_valid, 1'b0);
        check({tag, "_cmd_busy"}, bus.cmd_ready, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vmask_cmd_t c;

        bus.cmd_valid   = 1'b0;
        bus.v0          = '0;
        bus.mask_enable = 1'b0;
        bus.vstart      = '0;
        bus.vl          = '0;
        bus.flush       = 1'b0;
        bus.uop_ready   = 1'b1;

        // Reset
        tick();
        tick();
        check_idle_outputs("rst", 1'b0);
`ifdef VMASK_SEQ_POPCOUNT_EN
        check("rst_cnt", bus.active_cnt, '0);
`endif
        nrst = 1'b1;
        tick();
        check("rst_ready_rise", bus.cmd_ready, 1'b1);

        // Unmasked body, vl=10
        c = '{v0: '0, mask_enable: 1'b0, vstart: 8'd0, vl: 8'd10};
        issue("a", c);
        check("a_cmd_ready_low", bus.cmd_ready, 1'b0);
        check_uop("a_u0", 0, 4'b1111, 1'b0);
        tick();
        check_uop("a_u1", 1, 4'b1111, 1'b0);
        tick();
        check_uop("a_u2", 2, 4'b0011, 1'b1);
        tick();
        check_done("a");
`ifdef VMASK_SEQ_POPCOUNT_EN
        check("a_cnt", bus.active_cnt, 8'd10);
`endif
        tick();
        check_idle_outputs("a_after", 1'b1);

        // Masked with vstart, v0 scrambled every cycle after capture
        c = '{v0: 128'hA5F0, mask_enable: 1'b1, vstart: 8'd5, vl: 8'd16};
        issue("b", c);
        check_uop("b_u1", 1, 4'b1110, 1'b0);
        bus.v0 = {$urandom(), $urandom(), $urandom(), $urandom()};
        tick();
        check_uop("b_u2", 2, 4'b0101, 1'b0);
        bus.v0 = {$urandom(), $urandom(), $urandom(), $urandom()};
        tick();
        check_uop("b_u3", 3, 4'b1010, 1'b1);
        bus.v0 = ~bus.v0;
        tick();
        check_done("b");
`ifdef VMASK_SEQ_POPCOUNT_EN
        check("b_cnt", bus.active_cnt, 8'd7);
`endif
        tick();
        check_idle_outputs("b_after", 1'b1);
`ifdef VMASK_SEQ_POPCOUNT_EN
        check("b_cnt_hold", bus.active_cnt, 8'd7);
`endif

        // Empty commands
        c = '{v0: '1, mask_enable: 1'b0, vstart: 8'd0, vl: 8'd0};
        issue("e0", c);
        check_done("e0");
`ifdef VMASK_SEQ_POPCOUNT_EN
        check("e0_cnt", bus.active_cnt, '0);
`endif
        tick();
        check_idle_outputs("e0_after", 1'b1);
        c = '{v0: '1, mask_enable: 1'b0, vstart: 8'd8, vl: 8'd8};
        issue("e8", c);
        check_done("e8");
        tick();
        check_idle_outputs("e8_after", 1'b1);

        // Stall on uop 1
        c = '{v0: '0, mask_enable: 1'b0, vstart: 8'd0, vl: 8'd16};
        issue("s", c);
        check_uop("s_u0", 0, 4'b1111, 1'b0);
        tick();
        check_uop("s_u1", 1, 4'b1111, 1'b0);
        bus.uop_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check_uop("s_stall", 1, 4'b1111, 1'b0);
        end
        bus.uop_ready = 1'b1;
        tick();
        check_uop("s_u2", 2, 4'b1111, 1'b0);
        tick();
        check_uop("s_u3", 3, 4'b1111, 1'b1);
        tick();
        check_done("s");
`ifdef VMASK_SEQ_POPCOUNT_EN
        check("s_cnt", bus.active_cnt, 8'd16);
`endif
        tick();

        // Flush during uop 2, then a flushed command offer
        c = '{v0: '0, mask_enable: 1'b0, vstart: 8'd0, vl: 8'd32};
        issue("f", c);
        check_uop("f_u0", 0, 4'b1111, 1'b0);
        tick();
        check_uop("f_u1", 1, 4'b1111, 1'b0);
        tick();
        check_uop("f_u2", 2, 4'b1111, 1'b0);
        bus.flush = 1'b1;
        tick();
        check_idle_outputs("f_flushed", 1'b1);
`ifdef VMASK_SEQ_POPCOUNT_EN
        check("f_cnt", bus.active_cnt, '0);
`endif
        bus.cmd_valid = 1'b1;
        bus.vstart    = 8'd0;
        bus.vl        = 8'd8;
        tick();
        check_idle_outputs("f_dropped", 1'b1);
        bus.cmd_valid = 1'b0;
        bus.flush     = 1'b0;
        tick();
        check_idle_outputs("f_quiet", 1'b1);

        // Reset mid-command
        issue("r", c);
        check_uop("r_u0", 0, 4'b1111, 1'b0);
        tick();
        check_uop("r_u1", 1, 4'b1111, 1'b0);
        nrst = 1'b0;
        tick();
        check_idle_outputs("r_reset", 1'b0);
`ifdef VMASK_SEQ_POPCOUNT_EN
        check("r_cnt", bus.active_cnt, '0);
`endif
        nrst = 1'b1;
        tick();
        check_idle_outputs("r_after", 1'b1);

        // Fully masked micro-op is still issued
        c = '{v0: '0, mask_enable: 1'b1, vstart: 8'd0, vl: 8'd4};
        issue("m", c);
        check_uop("m_u0", 0, 4'b0000, 1'b1);
        tick();
        check_done("m");
`ifdef VMASK_SEQ_POPCOUNT_EN
        check("m_cnt", bus.active_cnt, '0);
`endif
        tick();
        check_idle_outputs("m_after", 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
